// File: rtl/cnn_mem_pkg.sv
// -----------------------------------------------------------------------------
// cnn_mem_pkg
// Shared constants for the CNN layer-memory port: data/address/select widths,
// csel encodings for each layer buffer, requester indices used by the layer
// memory arbiter, and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package cnn_mem_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 20;
    localparam int SEL_W    = 3;
    localparam int NUM_REQ  = 3;
    localparam int LOCK_MAX = 16;

    // Layer-memory bank selects
    localparam logic [SEL_W-1:0] L0_K0 = 3'b001;
    localparam logic [SEL_W-1:0] L0_K1 = 3'b010;
    localparam logic [SEL_W-1:0] L1_K0 = 3'b011;
    localparam logic [SEL_W-1:0] L1_K1 = 3'b100;
    localparam logic [SEL_W-1:0] L2    = 3'b101;

    // Requester slots on the arbiter
    localparam int REQ_CONV = 0;
    localparam int REQ_POOL = 1;
    localparam int REQ_FLAT = 2;

    typedef enum logic [0:0] {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// Combinational round-robin picker. Grants the first candidate at or after
// ptr_i, wrapping around; candidates are requesters not masked by excl_i.
//   req_i  : request vector
//   ptr_i  : highest-priority index this cycle
//   excl_i : requesters to skip this cycle
//   gnt_o  : one-hot grant (all zero when no candidate)
// -----------------------------------------------------------------------------
module rr_prio_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [N-1:0]     excl_i,
    output logic [N-1:0]     gnt_o
);

    logic [N-1:0] cand;
    logic         found;

    // Two passes: first the indices at/after ptr, then the wrapped-around
    // lower indices. The second pass only fires if the first found nothing.
    always_comb begin
        cand  = req_i & ~excl_i;
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && cand[i] && (i >= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && cand[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_mem_arbiter.sv
// -----------------------------------------------------------------------------
// layer_mem_arbiter
// Shares the single CNN layer-memory port between the conv writer, pool engine
// and flatten writer. Round-robin per beat, optional burst lock bounded by
// LOCK_MAX beats, registered memory command, read data routed back to the
// issuing requester two cycles after its grant.
//   clk, reset           : clock, async active-high reset
//   req/lock/we          : per-requester beat request, burst lock, write flag
//   sel/addr/wdata       : per-requester packed beat fields
//   gnt                  : one-hot combinational beat accept
//   rvalid/rdata         : read return, rdata zero unless rvalid
//   csel..crd            : registered memory command
//   cdata_rd             : memory read data, one cycle after crd
//   idle                 : no grant, no lock held, no read in flight
// -----------------------------------------------------------------------------
module layer_mem_arbiter
    import cnn_mem_pkg::*;
#(
    parameter int NUM_REQ  = cnn_mem_pkg::NUM_REQ,
    parameter int ADDR_W   = cnn_mem_pkg::ADDR_W,
    parameter int DATA_W   = cnn_mem_pkg::DATA_W,
    parameter int SEL_W    = cnn_mem_pkg::SEL_W,
    parameter int LOCK_MAX = cnn_mem_pkg::LOCK_MAX
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*SEL_W-1:0]  sel,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [SEL_W-1:0]          csel,
    output logic [ADDR_W-1:0]         caddr_wr,
    output logic [DATA_W-1:0]         cdata_wr,
    output logic                      cwr,
    output logic [ADDR_W-1:0]         caddr_rd,
    output logic                      crd,
    input  logic [DATA_W-1:0]         cdata_rd,
    output logic                      idle
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [NUM_REQ-1:0]   excl_q, excl_d;

    logic [NUM_REQ-1:0]   excl_eff, pick, gnt_w;
    logic [PTR_W-1:0]     pidx;

    logic [SEL_W-1:0]     csel_q;
    logic [ADDR_W-1:0]    caddr_wr_q, caddr_rd_q;
    logic [DATA_W-1:0]    cdata_wr_q;
    logic                 cwr_q, crd_q;

    logic                 we_m;
    logic [SEL_W-1:0]     sel_m;
    logic [ADDR_W-1:0]    addr_m;
    logic [DATA_W-1:0]    wdata_m;

    // One-hot read owner, one stage per cycle of memory latency
    logic [NUM_REQ-1:0]   rd1_q, rd2_q;

    // Former burst owner is skipped only if someone else is actually waiting;
    // otherwise it may be regranted straight away.
    assign excl_eff = ((req & ~excl_q) != '0) ? excl_q : '0;

    rr_prio_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .excl_i (excl_eff),
        .gnt_o  (pick)
    );

    always_comb begin
        pidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pidx = PTR_W'(i);
        end
    end

    assign cnt_inc = (cnt_q == CNT_W'(LOCK_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        gnt_w   = '0;
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        excl_d  = '0;
        case (state_q)
            S_ARB: begin
                gnt_w = pick;
                if (pick != '0) begin
                    ptr_d = (pidx == PTR_W'(NUM_REQ - 1)) ? '0 : pidx + PTR_W'(1);
                    if (lock[pidx]) begin
                        state_d = S_LOCK;
                        owner_d = pidx;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_LOCK: begin
                if (!req[owner_q]) begin
                    state_d = S_ARB;
                    cnt_d   = '0;
                end else begin
                    gnt_w[owner_q] = 1'b1;
                    cnt_d          = cnt_inc;
                    if (cnt_inc == CNT_W'(LOCK_MAX)) begin
                        // Beat limit reached: force rotation next cycle
                        state_d         = S_ARB;
                        cnt_d           = '0;
                        excl_d[owner_q] = 1'b1;
                    end else if (!lock[owner_q]) begin
                        state_d = S_ARB;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    // Beat fields of the granted requester
    always_comb begin
        we_m    = 1'b0;
        sel_m   = '0;
        addr_m  = '0;
        wdata_m = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_w[i]) begin
                we_m    = we[i];
                sel_m   = sel[i*SEL_W +: SEL_W];
                addr_m  = addr[i*ADDR_W +: ADDR_W];
                wdata_m = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            excl_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            excl_q  <= excl_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csel_q     <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            caddr_rd_q <= '0;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
        end else begin
            cwr_q <= (gnt_w != '0) &  we_m;
            crd_q <= (gnt_w != '0) & ~we_m;
            if (gnt_w != '0) begin
                csel_q <= sel_m;
                if (we_m) begin
                    caddr_wr_q <= addr_m;
                    cdata_wr_q <= wdata_m;
                end else begin
                    caddr_rd_q <= addr_m;
                end
            end
            rd1_q <= gnt_w & ~we;
            rd2_q <= rd1_q;
        end
    end

    assign gnt      = reset ? '0 : gnt_w;
    assign rvalid   = rd2_q;
    assign rdata    = (rd2_q != '0) ? cdata_rd : '0;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign cwr      = cwr_q;
    assign caddr_rd = caddr_rd_q;
    assign crd      = crd_q;
    assign idle     = !reset && (gnt_w == '0) && (state_q == S_ARB)
                      && (rd1_q == '0) && (rd2_q == '0);

endmodule
